nts_rx_access_arbiter: RTL and testbench
========================================

# nts_rx_access_arbiter

Shares the single read access port of the NTS engine's receive buffer between two requesters: port 0 (NTP/NTS parser) and port 1 (crypto/cookie engine). Each requester sees a private copy of the buffer's access-port protocol (rd_en pulse, wait, rd_dv, rd_data). The arbiter queues one pending read per requester, issues reads to the buffer one at a time with round-robin fairness, and returns data to the owner. It also provides a watchdog for buffer transactions that never complete.

## Interface
- ADDR_WIDTH, 8, buffer word-address width; byte address is ADDR_WIDTH+3 bits.
- TIMEOUT, 255, maximum cycles from buffer issue to completion before abort; 8-bit counter.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_areset_n  in  1  asynchronous, active-low reset.
- i_reqN_rd_en  in  1  (N=0,1) one-cycle read request; only legal while o_reqN_wait=0.
- i_reqN_addr  in  ADDR_WIDTH+3  byte address, sampled with rd_en.
- i_reqN_wordsize  in  3  0=8 bit, 1=16 bit, 2=32 bit, 3=64 bit; sampled with rd_en.
- o_reqN_wait  out  1  request pending or in flight.
- o_reqN_rd_dv  out  1  data valid.
- o_reqN_rd_data  out  64  read result, right-aligned as returned by the buffer.
- o_buf_rd_en  out  1  one-cycle read strobe to the buffer.
- o_buf_addr  out  ADDR_WIDTH+3  address to the buffer.
- o_buf_wordsize  out  3  word size to the buffer.
- i_buf_wait  in  1  buffer busy.
- i_buf_rd_dv  in  1  buffer data valid.
- i_buf_rd_data  in  64  buffer data.
- o_timeout  out  1  sticky flag; set on any watchdog abort and cleared only by reset.

## Operation
- Per-requester pending register holding valid, addr and wordsize. It is loaded when i_reqN_rd_en=1 and o_reqN_wait=0. The same edge sets o_reqN_wait=1 and clears o_reqN_rd_dv.
- An rd_en received while o_reqN_wait=1 is ignored: no state change, and the pending entry is not overwritten.
- FSM states: IDLE, ISSUE, BUSY, COMPLETE.
  - IDLE: if any pending entry is valid, select the owner, latch it, drive o_buf_addr/o_buf_wordsize and set o_buf_rd_en=1. Next state is ISSUE.
  - ISSUE: clear o_buf_rd_en. Next state is BUSY.
  - BUSY: wait for i_buf_wait=1, then go to COMPLETE.
  - COMPLETE: on i_buf_wait=0 and i_buf_rd_dv=1, load o_ownerN_rd_data from i_buf_rd_data, set o_owner_rd_dv=1, clear o_owner_wait, clear the owner's pending valid, and flip the priority pointer away from the owner. Next state is IDLE.
- Arbitration: if only one entry is pending, it wins. If both are pending, the pointer selects. After reset the pointer favours port 0. The pointer changes only on completion or abort.
- o_reqN_rd_dv and o_reqN_rd_data hold until that requester's next accepted rd_en.
- o_buf_addr and o_buf_wordsize hold their values from issue until the next issue.
- Watchdog:
  - The counter clears in IDLE and increments in ISSUE, BUSY and COMPLETE.
  - When the count reaches TIMEOUT, it aborts: o_timeout=1, the owner's rd_data is set to 64'h0, rd_dv=1, wait=0, pending is cleared, the pointer flips, and the FSM returns to IDLE.
  - An abort always fires in the cycle the count reaches TIMEOUT. If i_buf_rd_dv arrives in that same cycle, the abort still wins and the buffer data is discarded.
- A new request from the current owner can arrive in the same cycle as its completion. It is ignored because wait is still 1 at the sampling edge.
- A request from the other requester is accepted in any FSM state.

## Timing
- Reset values:
  - All outputs are 0: o_reqN_wait, o_reqN_rd_dv, o_reqN_rd_data, o_buf_rd_en, o_buf_addr, o_buf_wordsize, o_timeout.
  - FSM is in IDLE, pending entries are invalid, pointer=port 0.
  - Reset asserted mid-transaction returns everything to these values immediately, with no completion delivered. Any later i_buf_rd_dv is ignored because the FSM is in IDLE.
- Requester rd_en at cycle T, with the arbiter idle:
  - T+1: o_reqN_wait=1.
  - T+2: o_buf_rd_en=1, a single cycle.
  - Completion cycle C is the first COMPLETE cycle with i_buf_wait=0 and i_buf_rd_dv=1.
  - C+1: o_reqN_rd_dv=1 and o_reqN_wait=0.
- Back-to-back operation: after completion at C, the next pending read issues with o_buf_rd_en=1 at C+2.
- Minimum spacing between successive buffer strobes is 4 cycles.

## Test plan
- Single read:
  - Stimulus: port 0 requests addr 'b01_000, ws 3; buffer returns 64'habad1deac0fef00d.
  - Required: o_req0_rd_data matches, rd_dv=1, wait=0.
  - Required: port 1 outputs are unchanged and exactly one buffer strobe is issued.
- Simultaneous requests:
  - Stimulus: both ports pulse rd_en in the same cycle after reset.
  - Required: port 0 is served first, then port 1.
  - Stimulus: repeat the simultaneous requests.
  - Required: port 1 is served first.
  - Required: o_buf_addr and o_buf_wordsize match the owner at each strobe.
- Queued request:
  - Stimulus: port 1 requests while port 0's read is in BUSY.
  - Required: port 1 wait=1 immediately; its strobe occurs 2 cycles after port 0 completes.
  - Required: data is routed correctly, e.g. ws 0 at 'b00_001 returns 64'had only to port 1.
- Protocol violation:
  - Stimulus: port 0 pulses rd_en with a different addr while its wait=1.
  - Required: the original address is issued, there is no extra strobe, and the result is unchanged.
- Watchdog:
  - Stimulus: the buffer holds wait=1 for TIMEOUT+10 cycles.
  - Required: the owner gets rd_dv=1 with data 0, o_timeout=1.
  - Required: the next request is still served normally and o_timeout stays 1.
- Reset mid-operation:
  - Stimulus: assert i_areset_n=0 while in COMPLETE with both requests pending.
  - Required: all outputs are 0 and no rd_dv is delivered.
  - Required: after release, a port 1 request completes normally with a single strobe.

Source files
------------

// File: rtl/nts_rx_access_arbiter.sv
// Shares the NTS receive-buffer read port between the parser (port 0) and the
// crypto/cookie engine (port 1): one pending slot each, round-robin issue, watchdog.

module nts_rx_access_port #(
  parameter int AW = 11
) (
  input  logic          i_clk,
  input  logic          i_areset_n,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_addr,
  input  logic [2:0]    i_wordsize,
  input  logic          i_done,
  input  logic [63:0]   i_done_data,
  output logic          o_wait,
  output logic [AW-1:0] o_pend_addr,
  output logic [2:0]    o_pend_ws,
  output logic          o_rd_dv,
  output logic [63:0]   o_rd_data
);
  // o_wait doubles as the pending-valid bit: set on accept, cleared on delivery or abort.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      o_wait      <= 1'b0;
      o_pend_addr <= '0;
      o_pend_ws   <= '0;
      o_rd_dv     <= 1'b0;
      o_rd_data   <= '0;
    end else if (i_rd_en && !o_wait) begin
      o_wait      <= 1'b1;
      o_pend_addr <= i_addr;
      o_pend_ws   <= i_wordsize;
      o_rd_dv     <= 1'b0;
    end else if (i_done) begin
      o_wait      <= 1'b0;
      o_rd_dv     <= 1'b1;
      o_rd_data   <= i_done_data;
    end
  end
endmodule

module nts_rx_access_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_req0_rd_en,
  input  logic [ADDR_WIDTH+2:0] i_req0_addr,
  input  logic [2:0]            i_req0_wordsize,
  output logic                  o_req0_wait,
  output logic                  o_req0_rd_dv,
  output logic [63:0]           o_req0_rd_data,
  input  logic                  i_req1_rd_en,
  input  logic [ADDR_WIDTH+2:0] i_req1_addr,
  input  logic [2:0]            i_req1_wordsize,
  output logic                  o_req1_wait,
  output logic                  o_req1_rd_dv,
  output logic [63:0]           o_req1_rd_data,
  output logic                  o_buf_rd_en,
  output logic [ADDR_WIDTH+2:0] o_buf_addr,
  output logic [2:0]            o_buf_wordsize,
  input  logic                  i_buf_wait,
  input  logic                  i_buf_rd_dv,
  input  logic [63:0]           i_buf_rd_data,
  output logic                  o_timeout
);
  localparam int         AW      = ADDR_WIDTH + 3;
  localparam int         NUM_REQ = 2;
  localparam logic [7:0] TMO     = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, COMPLETE} state_t;
  state_t state_q, state_d;

  logic [NUM_REQ-1:0]         req_rd_en, req_wait, req_rd_dv, done;
  logic [NUM_REQ-1:0][AW-1:0] req_addr, pend_addr;
  logic [NUM_REQ-1:0][2:0]    req_ws, pend_ws;
  logic [NUM_REQ-1:0][63:0]   req_rd_data;
  logic [63:0]                done_data;
  logic                       owner_q, owner_d, ptr_q, ptr_d, sel, abort;
  logic [7:0]                 cnt_q, cnt_d;
  logic                       buf_rd_en_d, timeout_d;
  logic [AW-1:0]              buf_addr_d;
  logic [2:0]                 buf_ws_d;

  assign req_rd_en = {i_req1_rd_en, i_req0_rd_en};
  assign req_addr  = {i_req1_addr, i_req0_addr};
  assign req_ws    = {i_req1_wordsize, i_req0_wordsize};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
    nts_rx_access_port #(.AW(AW)) u_port (
      .i_clk       (i_clk),
      .i_areset_n  (i_areset_n),
      .i_rd_en     (req_rd_en[g]),
      .i_addr      (req_addr[g]),
      .i_wordsize  (req_ws[g]),
      .i_done      (done[g]),
      .i_done_data (done_data),
      .o_wait      (req_wait[g]),
      .o_pend_addr (pend_addr[g]),
      .o_pend_ws   (pend_ws[g]),
      .o_rd_dv     (req_rd_dv[g]),
      .o_rd_data   (req_rd_data[g])
    );
  end

  assign o_req0_wait    = req_wait[0];
  assign o_req0_rd_dv   = req_rd_dv[0];
  assign o_req0_rd_data = req_rd_data[0];
  assign o_req1_wait    = req_wait[1];
  assign o_req1_rd_dv   = req_rd_dv[1];
  assign o_req1_rd_data = req_rd_data[1];

  // A lone pending entry wins outright; the pointer only breaks ties.
  assign sel   = (&req_wait) ? ptr_q : req_wait[1];
  assign abort = (state_q != IDLE) && (cnt_q == TMO);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = (state_q == IDLE) ? 8'd0 : cnt_q + 8'd1;
    buf_rd_en_d = 1'b0;
    buf_addr_d  = o_buf_addr;
    buf_ws_d    = o_buf_wordsize;
    timeout_d   = o_timeout;
    done        = '0;
    done_data   = i_buf_rd_data;
    case (state_q)
      IDLE: if (|req_wait) begin
        owner_d     = sel;
        buf_rd_en_d = 1'b1;
        buf_addr_d  = pend_addr[sel];
        buf_ws_d    = pend_ws[sel];
        state_d     = ISSUE;
      end
      ISSUE: state_d = BUSY;
      BUSY:  if (i_buf_wait) state_d = COMPLETE;
      COMPLETE: if (!i_buf_wait && i_buf_rd_dv) begin
        done[owner_q] = 1'b1;
        ptr_d         = ~owner_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Watchdog beats a same-cycle completion; the late buffer data is dropped.
    if (abort) begin
      done          = '0;
      done[owner_q] = 1'b1;
      done_data     = '0;
      ptr_d         = ~owner_q;
      timeout_d     = 1'b1;
      state_d       = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      ptr_q          <= 1'b0;
      cnt_q          <= '0;
      o_buf_rd_en    <= 1'b0;
      o_buf_addr     <= '0;
      o_buf_wordsize <= '0;
      o_timeout      <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      o_buf_rd_en    <= buf_rd_en_d;
      o_buf_addr     <= buf_addr_d;
      o_buf_wordsize <= buf_ws_d;
      o_timeout      <= timeout_d;
    end
  end
endmodule

// File: tb/tb_nts_rx_access_arbiter.sv
// Directed bench for nts_rx_access_arbiter: cycle-level reference model plus
// hand-computed literal expectations for each scenario.

module tb_nts_rx_access_arbiter;
  localparam int ADDR_WIDTH = 8;
  localparam int TIMEOUT    = 255;
  localparam int AW         = ADDR_WIDTH + 3;

  logic          i_clk = 1'b0, i_areset_n = 1'b0;
  logic          i_req0_rd_en = 1'b0, i_req1_rd_en = 1'b0;
  logic [AW-1:0] i_req0_addr = '0, i_req1_addr = '0;
  logic [2:0]    i_req0_wordsize = '0, i_req1_wordsize = '0;
  logic          o_req0_wait, o_req0_rd_dv, o_req1_wait, o_req1_rd_dv;
  logic [63:0]   o_req0_rd_data, o_req1_rd_data;
  logic          o_buf_rd_en, o_timeout;
  logic [AW-1:0] o_buf_addr;
  logic [2:0]    o_buf_wordsize;
  logic          i_buf_wait = 1'b0, i_buf_rd_dv = 1'b0;
  logic [63:0]   i_buf_rd_data = '0;

  nts_rx_access_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_areset_n(i_areset_n),
    .i_req0_rd_en(i_req0_rd_en), .i_req0_addr(i_req0_addr), .i_req0_wordsize(i_req0_wordsize),
    .o_req0_wait(o_req0_wait), .o_req0_rd_dv(o_req0_rd_dv), .o_req0_rd_data(o_req0_rd_data),
    .i_req1_rd_en(i_req1_rd_en), .i_req1_addr(i_req1_addr), .i_req1_wordsize(i_req1_wordsize),
    .o_req1_wait(o_req1_wait), .o_req1_rd_dv(o_req1_rd_dv), .o_req1_rd_data(o_req1_rd_data),
    .o_buf_rd_en(o_buf_rd_en), .o_buf_addr(o_buf_addr), .o_buf_wordsize(o_buf_wordsize),
    .i_buf_wait(i_buf_wait), .i_buf_rd_dv(i_buf_rd_dv), .i_buf_rd_data(i_buf_rd_data),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  // Buffer responder: raises wait after a strobe, returns data buf_lat cycles later.
  int          buf_lat = 2, bcnt = 0;
  bit          bact = 0;
  logic [AW-1:0] baddr;
  logic [2:0]  bws;

  function automatic logic [63:0] buf_data(input logic [AW-1:0] a, input logic [2:0] ws);
    logic [63:0] d;
    if (a == 11'b01_000 && ws == 3'd3) return 64'habad1deac0fef00d;
    if (a == 11'b00_001 && ws == 3'd0) return 64'had;
    d = 64'h0123_4567_89ab_cdef ^ {53'h0, a};
    case (ws)
      3'd0:    d = d & 64'hff;
      3'd1:    d = d & 64'hffff;
      3'd2:    d = d & 64'hffff_ffff;
      default: d = d;
    endcase
    return d;
  endfunction

  initial begin
    forever begin
      @(posedge i_clk); #1;
      if (!i_areset_n) begin
        bact = 0; i_buf_wait = 0; i_buf_rd_dv = 0;
      end else begin
        i_buf_rd_dv = 0;
        i_buf_rd_data = 64'hdead_beef_dead_beef;
        if (o_buf_rd_en) begin
          bact = 1; bcnt = buf_lat; baddr = o_buf_addr; bws = o_buf_wordsize; i_buf_wait = 1;
        end else if (bact) begin
          bcnt--;
          if (bcnt == 0) begin
            i_buf_wait = 0; i_buf_rd_dv = 1; i_buf_rd_data = buf_data(baddr, bws); bact = 0;
          end
        end
      end
    end
  end

  // Reference model: requester-visible state plus the read currently in flight.
  bit          m_wait [2], m_dv [2];
  logic [63:0] m_data [2];
  logic [AW-1:0] m_paddr [2];
  logic [2:0]  m_pws [2];
  int          m_owner, m_age, m_ptr;
  bit          m_seen, m_strobe, m_timeout;
  logic [AW-1:0] m_baddr;
  logic [2:0]  m_bws;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wait[i] = 0; m_dv[i] = 0; m_data[i] = '0; m_paddr[i] = '0; m_pws[i] = '0;
    end
    m_owner = -1; m_age = 0; m_ptr = 0; m_seen = 0; m_strobe = 0; m_timeout = 0;
    m_baddr = '0; m_bws = '0;
  endtask

  task automatic deliver(input int o, input logic [63:0] d, input bit ab);
    m_data[o] = d; m_dv[o] = 1; m_wait[o] = 0; m_ptr = 1 - o; m_owner = -1;
    if (ab) m_timeout = 1;
  endtask

  task automatic model_step();
    bit acc0, acc1;
    int o;
    acc0 = i_req0_rd_en && !m_wait[0];
    acc1 = i_req1_rd_en && !m_wait[1];
    m_strobe = 0;
    if (m_owner < 0) begin
      if (m_wait[0] || m_wait[1]) begin
        if (m_wait[0] && m_wait[1]) o = m_ptr;
        else o = m_wait[1] ? 1 : 0;
        m_owner = o; m_age = 0; m_seen = 0; m_strobe = 1;
        m_baddr = m_paddr[o]; m_bws = m_pws[o];
      end
    end else if (m_age == TIMEOUT) deliver(m_owner, 64'h0, 1'b1);
    else if (m_seen && !i_buf_wait && i_buf_rd_dv) deliver(m_owner, i_buf_rd_data, 1'b0);
    else begin
      if (m_age >= 1 && i_buf_wait) m_seen = 1;
      m_age++;
    end
    if (acc0) begin m_wait[0] = 1; m_dv[0] = 0; m_paddr[0] = i_req0_addr; m_pws[0] = i_req0_wordsize; end
    if (acc1) begin m_wait[1] = 1; m_dv[1] = 0; m_paddr[1] = i_req1_addr; m_pws[1] = i_req1_wordsize; end
  endtask

  // Observation log of strobes and delivery edges.
  int          s_cyc [$];
  logic [AW-1:0] s_addr [$];
  logic [2:0]  s_ws [$];
  int          dv0_cyc = -1, dv1_cyc = -1, req0_cyc = -1;
  bit          p_dv0 = 0, p_dv1 = 0;

  function automatic int s_at(input int i);
    return (i < s_cyc.size()) ? s_cyc[i] : -1000;
  endfunction
  function automatic logic [AW-1:0] sa_at(input int i);
    return (i < s_addr.size()) ? s_addr[i] : '1;
  endfunction
  function automatic logic [2:0] sw_at(input int i);
    return (i < s_ws.size()) ? s_ws[i] : 3'b111;
  endfunction

  initial begin
    forever begin
      @(negedge i_clk);
      cyc++;
      if (!i_areset_n) model_reset();
      chk("req0_wait", o_req0_wait, m_wait[0]);
      chk("req1_wait", o_req1_wait, m_wait[1]);
      chk("req0_dv", o_req0_rd_dv, m_dv[0]);
      chk("req1_dv", o_req1_rd_dv, m_dv[1]);
      chk("req0_data", o_req0_rd_data, m_data[0]);
      chk("req1_data", o_req1_rd_data, m_data[1]);
      chk("buf_rd_en", o_buf_rd_en, m_strobe);
      chk("buf_addr", o_buf_addr, m_baddr);
      chk("buf_ws", o_buf_wordsize, m_bws);
      chk("timeout", o_timeout, m_timeout);
      if (o_buf_rd_en) begin s_cyc.push_back(cyc); s_addr.push_back(o_buf_addr); s_ws.push_back(o_buf_wordsize); end
      if (o_req0_rd_dv && !p_dv0) dv0_cyc = cyc;
      if (o_req1_rd_dv && !p_dv1) dv1_cyc = cyc;
      p_dv0 = o_req0_rd_dv; p_dv1 = o_req1_rd_dv;
      if (i_req0_rd_en && !o_req0_wait) req0_cyc = cyc;
      if (i_areset_n) model_step();
    end
  end

  task automatic clear_log();
    s_cyc.delete(); s_addr.delete(); s_ws.delete();
  endtask

  task automatic pulse(input bit e0, input logic [AW-1:0] a0, input logic [2:0] w0,
                       input bit e1, input logic [AW-1:0] a1, input logic [2:0] w1);
    @(posedge i_clk); #1;
    i_req0_rd_en = e0; i_req0_addr = a0; i_req0_wordsize = w0;
    i_req1_rd_en = e1; i_req1_addr = a1; i_req1_wordsize = w1;
    @(posedge i_clk); #1;
    i_req0_rd_en = 0; i_req1_rd_en = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge i_clk); #1;
    while ((o_req0_wait || o_req1_wait) && n < 600) begin @(negedge i_clk); #1; n++; end
    if (o_req0_wait || o_req1_wait) begin
      n_checks++; n_fail++;
      $display("FAIL %s: requests still waiting after %0d cycles, want idle", tag, n);
    end
  endtask

  task automatic wait_strobes(input int k, input string tag);
    int n = 0;
    while (s_cyc.size() < k && n < 50) begin @(negedge i_clk); #1; n++; end
    if (s_cyc.size() < k) begin
      n_checks++; n_fail++;
      $display("FAIL %s: saw %0d strobes, want %0d", tag, s_cyc.size(), k);
    end
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1; i_areset_n = 0;
    repeat (2) @(posedge i_clk); #1; i_areset_n = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: still running at %0t, limit 500000", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge i_clk); #1;
    chk("rst_wait0", o_req0_wait, 0);
    chk("rst_dv1", o_req1_rd_dv, 0);
    chk("rst_buf_rd_en", o_buf_rd_en, 0);
    chk("rst_timeout", o_timeout, 0);
    i_areset_n = 1;

    // Single read on port 0
    clear_log();
    pulse(1, 11'b01_000, 3, 0, '0, '0);
    wait_idle("single");
    chk("single_data", o_req0_rd_data, 64'habad1deac0fef00d);
    chk("single_dv", o_req0_rd_dv, 1);
    chk("single_wait", o_req0_wait, 0);
    chk("single_strobes", s_cyc.size(), 1);
    chk("single_issue_lat", s_at(0) - req0_cyc, 2);
    chk("single_done_lat", dv0_cyc - req0_cyc, 5);
    chk("single_p1_dv", o_req1_rd_dv, 0);
    chk("single_p1_data", o_req1_rd_data, 0);
    chk("model_pin_d0", m_data[0], 64'habad1deac0fef00d);

    // Simultaneous after reset: port 0 first
    do_reset();
    clear_log();
    pulse(1, 11'h010, 2, 1, 11'h020, 1);
    wait_idle("simul_a");
    chk("simul_a_strobes", s_cyc.size(), 2);
    chk("simul_a_addr0", sa_at(0), 11'h010);
    chk("simul_a_ws0", sw_at(0), 2);
    chk("simul_a_addr1", sa_at(1), 11'h020);
    chk("simul_a_ws1", sw_at(1), 1);
    chk("simul_a_spacing", s_at(1) - s_at(0), 4);
    chk("simul_a_order", dv0_cyc < dv1_cyc, 1);

    // Lone port 0 read leaves the pointer on port 1, then both again: port 1 first
    pulse(1, 11'h018, 0, 0, '0, '0);
    wait_idle("lone");
    clear_log();
    pulse(1, 11'h028, 3, 1, 11'h038, 2);
    wait_idle("simul_b");
    chk("simul_b_addr0", sa_at(0), 11'h038);
    chk("simul_b_ws0", sw_at(0), 2);
    chk("simul_b_addr1", sa_at(1), 11'h028);
    chk("simul_b_ws1", sw_at(1), 3);
    chk("simul_b_order", dv1_cyc < dv0_cyc, 1);

    // Port 1 queued while port 0 is in flight
    buf_lat = 6;
    clear_log();
    pulse(1, 11'b01_000, 3, 0, '0, '0);
    wait_strobes(1, "queued_first");
    pulse(0, '0, '0, 1, 11'b00_001, 0);
    @(negedge i_clk); #1;
    chk("queued_p1_wait", o_req1_wait, 1);
    wait_idle("queued");
    chk("queued_strobe_gap", s_at(1) - dv0_cyc, 1);
    chk("queued_addr1", sa_at(1), 11'b00_001);
    chk("queued_p1_data", o_req1_rd_data, 64'had);
    chk("queued_p0_data", o_req0_rd_data, 64'habad1deac0fef00d);

    // Protocol violation: second rd_en while waiting is ignored
    buf_lat = 8;
    clear_log();
    pulse(1, 11'h030, 2, 0, '0, '0);
    repeat (2) @(posedge i_clk);
    pulse(1, 11'h7f8, 3, 0, '0, '0);
    wait_idle("violation");
    chk("viol_strobes", s_cyc.size(), 1);
    chk("viol_addr", sa_at(0), 11'h030);
    chk("viol_data", o_req0_rd_data, 64'h89abcddf);

    // Watchdog: buffer stalls past TIMEOUT
    buf_lat = TIMEOUT + 10;
    clear_log();
    pulse(0, '0, '0, 1, 11'h040, 3);
    wait_idle("watchdog");
    chk("wd_dv", o_req1_rd_dv, 1);
    chk("wd_data", o_req1_rd_data, 0);
    chk("wd_timeout", o_timeout, 1);
    chk("wd_abort_lat", dv1_cyc - s_at(0), TIMEOUT + 1);
    begin
      int n = 0;
      while (bact && n < 100) begin @(negedge i_clk); #1; n++; end
      chk("wd_buf_drained", bact, 0);
    end
    buf_lat = 2;
    clear_log();
    pulse(1, 11'h048, 1, 0, '0, '0);
    wait_idle("post_wd");
    chk("post_wd_data", o_req0_rd_data, 64'hcda7);
    chk("post_wd_timeout", o_timeout, 1);
    chk("post_wd_strobes", s_cyc.size(), 1);

    // Reset while a read sits in COMPLETE with the other port pending
    buf_lat = 20;
    clear_log();
    pulse(1, 11'h050, 3, 1, 11'h058, 3);
    wait_strobes(1, "rst_mid");
    repeat (2) @(negedge i_clk);
    @(posedge i_clk); #1; i_areset_n = 0;
    #1;
    chk("rstmid_wait0", o_req0_wait, 0);
    chk("rstmid_wait1", o_req1_wait, 0);
    chk("rstmid_timeout", o_timeout, 0);
    chk("rstmid_buf_addr", o_buf_addr, 0);
    repeat (3) @(posedge i_clk); #1; i_areset_n = 1;
    repeat (30) @(negedge i_clk);
    #1;
    chk("rstmid_no_dv0", o_req0_rd_dv, 0);
    chk("rstmid_no_dv1", o_req1_rd_dv, 0);
    chk("rstmid_strobes", s_cyc.size(), 1);
    buf_lat = 2;
    clear_log();
    pulse(0, '0, '0, 1, 11'h060, 2);
    wait_idle("post_rst");
    chk("post_rst_strobes", s_cyc.size(), 1);
    chk("post_rst_dv", o_req1_rd_dv, 1);
    chk("post_rst_data", o_req1_rd_data, 64'h89abcd8f);

    repeat (2) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
